// File: rtl/uart_mem_bridge_pkg.sv
// Shared definitions for the UART memory bridge: op codes, FSM encoding,
// length-code width and the layout of the host-bound command byte.
// Helper function builds the command byte so the FSM and any host model agree.
package uart_mem_bridge_pkg;

   // Request direction as carried in the command byte
   localparam logic OP_RD = 1'b0;
   localparam logic OP_WR = 1'b1;

   // Length code: number of bytes is len + 1
   localparam int LEN_W = 2;

   // Address is always sent as this many bytes, LSB first
   localparam int ADDR_BYTES = 4;

   // Command byte layout: {op, 5'b0, len}
   localparam int CMD_OP_BIT  = 7;
   localparam int CMD_LEN_LSB = 0;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      TX_CMD  = 3'd1,
      TX_ADDR = 3'd2,
      TX_DATA = 3'd3,
      RX_DATA = 3'd4,
      RX_WACK = 3'd5,
      ACK_R   = 3'd6,
      ACK_W   = 3'd7
   } state_t;

   function automatic logic [7:0] cmd_byte(input logic op, input logic [LEN_W-1:0] len);
      logic [7:0] b;
      b = 8'h00;
      b[CMD_OP_BIT] = op;
      b[CMD_LEN_LSB +: LEN_W] = len;
      return b;
   endfunction

endpackage

// File: rtl/uart_mem_bridge_timer.sv
// Receive watchdog: loadable down-counter that pulses expire on the last idle cycle.
// Latency: expire is combinational on the TIMEOUT-th consecutive run cycle after a load.
// No backpressure; load wins over clear, clear wins over counting.
module uart_mem_bridge_timer #(
   parameter int TIMEOUT = 65535,
   parameter int TO_W    = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic clear,
   input  logic run,
   output logic expire
);

   logic [TO_W-1:0] cnt;

   // Reload on each received byte / RX entry, park at zero when idle, else count down
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= TO_W'(TIMEOUT);
      end else if (clear) begin
         cnt <= '0;
      end else if (run && cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   // Fires during the final idle cycle so the FSM leaves on the following edge
   always_comb begin
      expire = run && !load && (cnt == TO_W'(1));
   end

endmodule

// File: rtl/uart_mem_bridge.sv
// Bridges one read and one write request port onto a UART byte stream and back.
// Latency: read len 0 with an always-ready host acks 7 cycles after the accept cycle.
// Backpressure: TX bytes hold until tx_ready; RX is always drained, stray bytes flagged.
module uart_mem_bridge
   import uart_mem_bridge_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 65535,
   parameter int TO_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              rd_en,
   input  logic [1:0]        rd_len,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_ack,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic              wr_en,
   input  logic [1:0]        wr_len,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              timeout_err,
   output logic              stray_rx
);

   state_t                  state_q;
   state_t                  state_n;

   logic                    op_q;
   logic [LEN_W-1:0]        len_q;
   logic [ADDR_BYTES*8-1:0] addr_q;
   logic [DATA_W-1:0]       data_q;
   logic [DATA_W-1:0]       rd_data_q;
   logic [2:0]              idx_q;
   logic                    rx_live_q;
   logic                    timeout_q;
   logic                    stray_q;

   logic                    tx_fire;
   logic                    rx_fire;
   logic                    in_rx;
   logic                    enter_rx;
   logic                    last_byte;
   logic                    expire;
   logic                    accept_wr;
   logic                    accept_rd;

   assign tx_fire   = tx_valid && tx_ready;
   assign rx_fire   = rx_valid && rx_ready;
   assign in_rx     = (state_q == RX_DATA) || (state_q == RX_WACK);
   assign enter_rx  = ((state_n == RX_DATA) || (state_n == RX_WACK)) && !in_rx;
   assign last_byte = (idx_q == {1'b0, len_q});
   assign accept_wr = (state_q == IDLE) && wr_en;
   assign accept_rd = (state_q == IDLE) && !wr_en && rd_en;

   uart_mem_bridge_timer #(
      .TIMEOUT (TIMEOUT),
      .TO_W    (TO_W)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .load   (enter_rx || (in_rx && rx_fire)),
      .clear  (!in_rx),
      .run    (in_rx && !rx_fire),
      .expire (expire)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_n;
      end
   end

   // Next-state: write wins a tie so a read issued alongside sees the written data
   always_comb begin
      state_n = state_q;
      case (state_q)
         IDLE: begin
            if (accept_wr || accept_rd) begin
               state_n = TX_CMD;
            end
         end
         TX_CMD: begin
            if (tx_fire) begin
               state_n = TX_ADDR;
            end
         end
         TX_ADDR: begin
            if (tx_fire && idx_q == 3'(ADDR_BYTES - 1)) begin
               state_n = (op_q == OP_WR) ? TX_DATA : RX_DATA;
            end
         end
         TX_DATA: begin
            if (tx_fire && last_byte) begin
               state_n = RX_WACK;
            end
         end
         RX_DATA: begin
            if ((rx_fire && last_byte) || expire) begin
               state_n = ACK_R;
            end
         end
         RX_WACK: begin
            if (rx_fire || expire) begin
               state_n = ACK_W;
            end
         end
         ACK_R: begin
            if (!rd_en) begin
               state_n = IDLE;
            end
         end
         ACK_W: begin
            if (!wr_en) begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Outputs decoded from state; tx_data only depends on latched fields so it is stable under stall
   always_comb begin
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      rd_ack   = 1'b0;
      wr_ack   = 1'b0;
      case (state_q)
         TX_CMD: begin
            tx_valid = 1'b1;
            tx_data  = cmd_byte(op_q, len_q);
         end
         TX_ADDR: begin
            tx_valid = 1'b1;
            tx_data  = addr_q[{idx_q[1:0], 3'b000} +: 8];
         end
         TX_DATA: begin
            tx_valid = 1'b1;
            tx_data  = data_q[{idx_q[1:0], 3'b000} +: 8];
         end
         ACK_R:   rd_ack = 1'b1;
         ACK_W:   wr_ack = 1'b1;
         default: ;
      endcase
   end

   // Request capture and byte index; index restarts on every state change
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q   <= OP_RD;
         len_q  <= '0;
         addr_q <= '0;
         data_q <= '0;
         idx_q  <= '0;
      end else begin
         if (accept_wr) begin
            op_q   <= OP_WR;
            len_q  <= wr_len;
            addr_q <= (ADDR_BYTES*8)'(wr_addr);
            data_q <= wr_data;
         end else if (accept_rd) begin
            op_q   <= OP_RD;
            len_q  <= rd_len;
            addr_q <= (ADDR_BYTES*8)'(rd_addr);
            data_q <= '0;
         end
         if (state_n != state_q) begin
            idx_q <= '0;
         end else if ((tx_fire && (state_q == TX_ADDR || state_q == TX_DATA)) ||
                      (rx_fire && state_q == RX_DATA)) begin
            idx_q <= idx_q + 3'd1;
         end
      end
   end

   // Read data: cleared on RX entry so bytes never fetched read back as zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_q <= '0;
      end else if (state_n == RX_DATA && state_q != RX_DATA) begin
         rd_data_q <= '0;
      end else if (state_q == RX_DATA && rx_fire) begin
         rd_data_q[{idx_q[1:0], 3'b000} +: 8] <= rx_data;
      end
   end

   // Sticky status and RX drain enable (held low only while in reset)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_live_q <= 1'b0;
         timeout_q <= 1'b0;
         stray_q   <= 1'b0;
      end else begin
         rx_live_q <= 1'b1;
         if (in_rx && expire) begin
            timeout_q <= 1'b1;
         end
         if (rx_fire && !in_rx) begin
            stray_q <= 1'b1;
         end
      end
   end

   assign rd_data     = rd_data_q;
   assign rx_ready    = rx_live_q;
   assign timeout_err = timeout_q;
   assign stray_rx    = stray_q;

endmodule

// File: tb/tb_uart_mem_bridge.sv
module tb_uart_mem_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] rd_addr;
   logic        rd_en;
   logic [1:0]  rd_len;
   logic [31:0] rd_data;
   logic        rd_ack;
   logic [31:0] wr_addr;
   logic        wr_en;
   logic [1:0]  wr_len;
   logic [31:0] wr_data;
   logic        wr_ack;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        timeout_err;
   logic        stray_rx;

   int tests = 0;
   int fails = 0;
   logic [7:0] txq[$];
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   uart_mem_bridge #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .TIMEOUT (100),
      .TO_W    (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rd_addr     (rd_addr),
      .rd_en       (rd_en),
      .rd_len      (rd_len),
      .rd_data     (rd_data),
      .rd_ack      (rd_ack),
      .wr_addr     (wr_addr),
      .wr_en       (wr_en),
      .wr_len      (wr_len),
      .wr_data     (wr_data),
      .wr_ack      (wr_ack),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .timeout_err (timeout_err),
      .stray_rx    (stray_rx)
   );

   // Host-side capture of every byte the bridge hands to the UART
   always @(posedge clk) begin
      if (tx_valid && tx_ready) txq.push_back(tx_data);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_tx(input int n, input string tag);
      int k = 0;
      while (txq.size() < n && k < 300) begin
         tick();
         k++;
      end
      check(tag, txq.size(), n);
   endtask

   task automatic check_frame(input string tag);
      check({tag, "_len"}, txq.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < txq.size()) check($sformatf("%s_b%0d", tag, i), txq[i], exp_q[i]);
      end
   endtask

   task automatic send_rx(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic wait_ack(input bit is_wr, output int n);
      n = 0;
      while (((is_wr ? wr_ack : rd_ack) !== 1'b1) && n < 300) begin
         tick();
         n++;
      end
   endtask

   initial begin
      int n;
      rst = 1'b1;
      rd_addr = '0; rd_en = 1'b0; rd_len = '0;
      wr_addr = '0; wr_en = 1'b0; wr_len = '0; wr_data = '0;
      tx_ready = 1'b1; rx_data = '0; rx_valid = 1'b0;
      repeat (3) tick();
      check("rst_rd_ack", rd_ack, 0);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_rx_ready", rx_ready, 0);
      check("rst_rd_data", rd_data, 0);
      check("rst_sticky", {timeout_err, stray_rx}, 0);
      rst = 1'b0;
      tick();
      check("post_rst_rx_ready", rx_ready, 1);

      // Read 0x1234 len 3
      txq.delete();
      rd_addr = 32'h0000_1234; rd_len = 2'd3; rd_en = 1'b1;
      wait_tx(5, "rd1_tx_wait");
      exp_q = {8'h03, 8'h34, 8'h12, 8'h00, 8'h00};
      check_frame("rd1");
      rd_addr = 32'hDEAD_BEEF;
      send_rx(8'h11); send_rx(8'h22); send_rx(8'h33); send_rx(8'h44);
      wait_ack(1'b0, n);
      check("rd1_ack", rd_ack, 1);
      check("rd1_data", rd_data, 32'h4433_2211);
      repeat (3) tick();
      check("rd1_ack_held", rd_ack, 1);
      rd_en = 1'b0;
      tick();
      check("rd1_ack_drop", rd_ack, 0);

      // Write 0x100 len 1
      txq.delete();
      wr_addr = 32'h0000_0100; wr_len = 2'd1; wr_data = 32'hAABB_CCDD; wr_en = 1'b1;
      wait_tx(7, "wr1_tx_wait");
      exp_q = {8'h81, 8'h00, 8'h01, 8'h00, 8'h00, 8'hDD, 8'hCC};
      check_frame("wr1");
      check("wr1_no_ack_yet", wr_ack, 0);
      send_rx(8'h77);
      wait_ack(1'b1, n);
      check("wr1_ack", wr_ack, 1);
      check("wr1_rd_data_held", rd_data, 32'h4433_2211);
      wr_en = 1'b0;
      tick();
      check("wr1_ack_drop", wr_ack, 0);

      // Simultaneous read and write: write frame first
      txq.delete();
      rd_addr = 32'h55; rd_len = 2'd0;
      wr_addr = 32'h66; wr_len = 2'd0; wr_data = 32'h99;
      rd_en = 1'b1; wr_en = 1'b1;
      wait_tx(6, "both_wr_wait");
      repeat (5) tick();
      exp_q = {8'h80, 8'h66, 8'h00, 8'h00, 8'h00, 8'h99};
      check_frame("both_wr");
      send_rx(8'h01);
      wait_ack(1'b1, n);
      check("both_wr_ack", wr_ack, 1);
      check("both_rd_not_ack", rd_ack, 0);
      wr_en = 1'b0;
      txq.delete();
      wait_tx(5, "both_rd_wait");
      exp_q = {8'h00, 8'h55, 8'h00, 8'h00, 8'h00};
      check_frame("both_rd");
      send_rx(8'hEE);
      wait_ack(1'b0, n);
      check("both_rd_data", rd_data, 32'h0000_00EE);
      rd_en = 1'b0;
      tick();

      // TX stall mid-address
      txq.delete();
      rd_addr = 32'h1234_5678; rd_len = 2'd0; rd_en = 1'b1;
      wait_tx(2, "stall_pre");
      tx_ready = 1'b0;
      check("stall_tx_data0", tx_data, 8'h56);
      repeat (10) tick();
      check("stall_tx_valid", tx_valid, 1);
      check("stall_tx_data1", tx_data, 8'h56);
      check("stall_no_skip", txq.size(), 2);
      tx_ready = 1'b1;
      wait_tx(5, "stall_post");
      exp_q = {8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
      check_frame("stall");
      send_rx(8'h3C);
      wait_ack(1'b0, n);
      check("stall_rd_data", rd_data, 32'h0000_003C);
      rd_en = 1'b0;
      tick();

      // Timeout with 2 of 4 bytes
      txq.delete();
      rd_addr = 32'h40; rd_len = 2'd3; rd_en = 1'b1;
      wait_tx(5, "to_tx_wait");
      send_rx(8'hAA); send_rx(8'hBB);
      wait_ack(1'b0, n);
      check("to_idle_cycles", n, 100);
      check("to_ack", rd_ack, 1);
      check("to_rd_data", rd_data, 32'h0000_BBAA);
      check("to_err", timeout_err, 1);
      rd_en = 1'b0;
      tick();
      check("to_ack_drop", rd_ack, 0);
      check("to_err_sticky", timeout_err, 1);

      // Stray RX byte in IDLE
      check("stray_before", stray_rx, 0);
      send_rx(8'h5A);
      tick();
      check("stray_set", stray_rx, 1);
      check("stray_no_ack", {rd_ack, wr_ack, tx_valid}, 0);

      // Reset mid TX_ADDR
      txq.delete();
      rd_addr = 32'h0000_0A0B; rd_len = 2'd1; rd_en = 1'b1;
      wait_tx(2, "mid_rst_wait");
      check("mid_rst_in_frame", tx_valid, 1);
      rst = 1'b1;
      #1;
      check("mid_rst_outs", {tx_valid, tx_data, rx_ready, rd_ack, wr_ack, timeout_err, stray_rx}, 0);
      check("mid_rst_rd_data", rd_data, 0);
      rd_en = 1'b0;
      tick();
      rst = 1'b0;
      repeat (3) tick();
      check("after_rst_idle", {tx_valid, rd_ack, wr_ack}, 0);
      check("after_rst_rx_ready", rx_ready, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_mem_bridge.md
Name: uart_mem_bridge

Overview:
- Memory-side stage directly downstream of the MMU.
- Takes one read request port and one write request port, each carrying address, length code and write data.
- Serialises each request into a byte frame for the UART transmitter and collects the host's reply bytes from the UART receiver.
- Returns read data and acknowledges each request with a 4-phase level handshake.

Parameters:
ADDR_W, 32, request address width; transmitted as 4 bytes LSB first, upper bits beyond ADDR_W sent as 0
DATA_W, 32, data width; fixed at 4 bytes
TIMEOUT, 65535, max idle cycles waiting for one RX byte before abort
TO_W, 16, width of the timeout counter

Ports:
clk  in  1  clock
rst  in  1  reset
rd_addr  in  ADDR_W  read byte address
rd_en  in  1  read request level, held until rd_ack
rd_len  in  2  read length code: bytes = rd_len+1
rd_data  out  DATA_W  read result, zero-extended
rd_ack  out  1  read done level
wr_addr  in  ADDR_W  write byte address
wr_en  in  1  write request level
wr_len  in  2  write length code: bytes = wr_len+1
wr_data  in  DATA_W  write data, low bytes used
wr_ack  out  1  write done level
tx_data  out  8  byte to UART TX
tx_valid  out  1  tx byte valid
tx_ready  in  1  UART TX accepts byte
rx_data  in  8  byte from UART RX
rx_valid  in  1  rx byte valid
rx_ready  out  1  bridge consumes rx byte
timeout_err  out  1  sticky: a request timed out
stray_rx  out  1  sticky: RX byte arrived while not expected

Behaviour:
- rst is asynchronous, active-high; clock is clk. All outputs reset to 0; FSM resets to IDLE.
- Byte transfers: a TX byte moves on a cycle with tx_valid & tx_ready. An RX byte moves on a cycle with rx_valid & rx_ready.
- Frame, host bound:
  - Command byte {op, 5'b0, len[1:0]}; op=1 for write, 0 for read.
  - 4 address bytes, LSB first.
  - Writes only: len+1 data bytes from wr_data, LSB first.
- Reply: reads return len+1 data bytes, LSB first. Writes return 1 acknowledge byte; its value is ignored.
- FSM states: IDLE, TX_CMD, TX_ADDR, TX_DATA, RX_DATA, RX_WACK, ACK_R, ACK_W.
- IDLE:
  - Accepts a request only when the matching ack is low.
  - If wr_en and rd_en are both high in the same cycle, write wins (read-after-write ordering). The read stays pending and starts after the write's ack cycle completes.
  - On accept: latch addr, len, data and op into internal registers. Later changes on the inputs are ignored.
  - Next state TX_CMD, with tx_valid=1 in the following cycle.
- TX_CMD -> TX_ADDR -> (write: TX_DATA | read: RX_DATA); TX_DATA -> RX_WACK.
  - A 3-bit byte index counts inside TX_ADDR/TX_DATA/RX_DATA.
  - tx_valid is held and tx_data is stable until tx_ready.
- RX_DATA:
  - rx_ready=1. Byte k is written to rd_data[8k+7:8k].
  - rd_data is cleared to 0 on entry, so unfetched bytes read 0.
  - After byte len -> ACK_R.
- RX_WACK: rx_ready=1; one byte -> ACK_W.
- ACK_R/ACK_W:
  - Assert rd_ack or wr_ack. Hold it until the corresponding en is low, then drop the ack and go to IDLE.
  - rd_data is held stable until the next read starts.
- Minimum latency, read len 0 with tx_ready and rx_valid tied high: accept cycle, then 5 TX cycles, then 1 RX cycle; ack rises on cycle 7.
- Timeout:
  - The counter resets on every RX byte and on entry to an RX state, and counts only in RX_DATA/RX_WACK.
  - On reaching TIMEOUT: set timeout_err, go to ACK_R/ACK_W with bytes received so far (rest 0).
  - timeout_err is cleared only by rst.
- Stray RX: outside the RX states, rx_ready=1 (drain). Any consumed byte sets stray_rx (sticky) and is discarded.
- en dropped before ack: the request still completes. The ack pulses for 1 cycle (en already low), then IDLE.
- Reset mid-frame: the frame is aborted immediately; the host side must resynchronise (outside scope).

Decomposition:
- Shared package: op codes (OP_RD=0, OP_WR=1), state encoding, length-code width (2), frame-field positions.
- One sub-module, uart_mem_bridge_timer: loadable down-counter with a clear input, producing the expire pulse.
- The FSM stays in the top level.

Test Plan:
- Read 0x00001234 len 3, host replies 0x11 0x22 0x33 0x44 → TX 0x03,0x34,0x12,0x00,0x00; rd_data=0x44332211; rd_ack high until rd_en low.
- Write 0x00000100 len 1, data 0xAABBCCDD → TX 0x81,0x00,0x01,0x00,0x00,0xDD,0xCC; after one RX byte wr_ack=1.
- rd_en and wr_en rise in the same cycle → complete write frame first, then read frame; no interleaved bytes.
- tx_ready low for 10 cycles mid-address → tx_data stable and no byte skipped; frame identical to the no-stall case.
- Read len 3, only 2 RX bytes, TIMEOUT=100 → after 100 idle cycles rd_data=0x0000BBAA, timeout_err=1, rd_ack=1.
- rx byte 0x5A in IDLE → stray_rx=1, no ack. Then assert rst mid-TX_ADDR → all outputs 0, state IDLE.
